// File: rtl/iir_cascade_tdm.sv
// Time-multiplexed stereo biquad cascade: one shared multiplier walks every section
// of the selected channel, with double-buffered coefficients committed only between samples.
module iir_cascade_tdm #(
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 16,
  parameter int FRAC    = 14,
  parameter int NUM_SEC = 2,
  parameter int ACC_W   = 40
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         l_r_clk,
  input  logic [DATA_W-1:0]            sample_in,
  input  logic                         coef_wr_en,
  input  logic [$clog2(5*NUM_SEC)-1:0] coef_wr_addr,
  input  logic [COEF_W-1:0]            coef_wr_data,
  input  logic                         coef_commit,
  input  logic                         overrun_clr,
  output logic [DATA_W-1:0]            sample_out,
  output logic                         out_valid,
  output logic                         out_chan,
  output logic                         busy,
  output logic                         overrun
);
  localparam int NCOEF  = 5 * NUM_SEC;
  localparam int ADDR_W = $clog2(NCOEF);
  localparam int SEC_W  = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [COEF_W-1:0]        B0_ONE = COEF_W'(1) << FRAC;
  localparam logic signed [ACC_W-1:0]  HALF   = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0]  MAXV   = $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0]  MINV   = $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

  typedef enum logic [1:0] {IDLE, MAC, SCALE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             k_q, k_d;
  logic [SEC_W-1:0]       sec_q, sec_d;
  logic                   s1_q, s2_q, s3_q, edge_p, accept, last_sec, commit_now, pend_q;
  logic                   ch_q;
  logic [NCOEF-1:0][COEF_W-1:0]            shadow_q, active_q;
  logic [NUM_SEC-1:0][1:0][DATA_W-1:0]     x1_q, x2_q, y1_q, y2_q;
  logic signed [DATA_W-1:0]                cur_x_q, opnd, y_sat;
  logic signed [COEF_W-1:0]                coef;
  logic signed [PROD_W-1:0]                prod;
  logic signed [ACC_W-1:0]                 prod_ext, acc_q, rnd, shf;
  logic [ADDR_W-1:0]                       caddr;

  // l_r_clk is asynchronous; E fires on either edge of the synchronised level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) {s1_q, s2_q, s3_q} <= '0;
    else        {s1_q, s2_q, s3_q} <= {l_r_clk, s1_q, s2_q};
  end
  assign edge_p   = s2_q ^ s3_q;
  assign busy     = (state_q != IDLE);
  assign last_sec = (sec_q == SEC_W'(NUM_SEC - 1));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sec_d   = sec_q;
    accept  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (edge_p) begin
          accept  = 1'b1;
          state_d = MAC;
          k_d     = '0;
          sec_d   = '0;
        end
      end
      MAC: begin
        if (k_q == 3'd4) state_d = SCALE;
        else             k_d = k_q + 3'd1;
      end
      SCALE: begin
        if (last_sec) state_d = DONE;
        else begin
          state_d = MAC;
          k_d     = '0;
          sec_d   = sec_q + SEC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      sec_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sec_q   <= sec_d;
    end
  end

  // The single shared multiplier: operand and coefficient steered by section/tap
  assign caddr = ADDR_W'(32'(sec_q) * 5 + 32'(k_q));
  assign coef  = active_q[caddr];
  always_comb begin
    opnd = cur_x_q;
    case (k_q)
      3'd1:    opnd = x1_q[sec_q][ch_q];
      3'd2:    opnd = x2_q[sec_q][ch_q];
      3'd3:    opnd = y1_q[sec_q][ch_q];
      3'd4:    opnd = y2_q[sec_q][ch_q];
      default: opnd = cur_x_q;
    endcase
  end
  assign prod     = coef * opnd;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  always_comb begin
    rnd = acc_q + HALF;
    shf = rnd >>> FRAC;
    if (shf > MAXV)      y_sat = MAXV[DATA_W-1:0];
    else if (shf < MINV) y_sat = MINV[DATA_W-1:0];
    else                 y_sat = shf[DATA_W-1:0];
  end

  // Commits wait for IDLE so a sample never sees a half-updated coefficient set
  assign commit_now = (state_q == IDLE) && (pend_q || coef_commit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= 1'b0;
      for (int i = 0; i < NCOEF; i++) begin
        shadow_q[i] <= (i % 5 == 0) ? B0_ONE : '0;
        active_q[i] <= (i % 5 == 0) ? B0_ONE : '0;
      end
    end else begin
      if (coef_wr_en && (coef_wr_addr < ADDR_W'(NCOEF))) shadow_q[coef_wr_addr] <= coef_wr_data;
      if (commit_now) begin
        active_q <= shadow_q;
        pend_q   <= 1'b0;
      end else if (coef_commit) begin
        pend_q   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overrun <= 1'b0;
    else if (overrun_clr) overrun <= 1'b0;
    else if (edge_p && (state_q == MAC || state_q == SCALE)) overrun <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_x_q    <= '0;
      ch_q       <= 1'b0;
      acc_q      <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      y1_q       <= '0;
      y2_q       <= '0;
      sample_out <= '0;
      out_chan   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        cur_x_q <= sample_in;
        ch_q    <= s2_q;
      end
      if (state_q == MAC) begin
        if (k_q == 3'd0)      acc_q <= prod_ext;
        else if (k_q < 3'd3)  acc_q <= acc_q + prod_ext;
        else                  acc_q <= acc_q - prod_ext;
      end
      if (state_q == SCALE) begin
        x2_q[sec_q][ch_q] <= x1_q[sec_q][ch_q];
        x1_q[sec_q][ch_q] <= cur_x_q;
        y2_q[sec_q][ch_q] <= y1_q[sec_q][ch_q];
        y1_q[sec_q][ch_q] <= y_sat;
        cur_x_q           <= y_sat;
        if (last_sec) begin
          sample_out <= y_sat;
          out_chan   <= ch_q;
          out_valid  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/iir_cascade_tdm.md
IIR_CASCADE_TDM -- requirements
Module: iir_cascade_tdm

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits (signed).
REQ-002 SHALL have parameter COEF_W, default 16, coefficient width in bits (signed).
REQ-003 SHALL have parameter FRAC, default 14, number of coefficient fractional bits (Q2.14 at default).
REQ-004 SHALL have parameter NUM_SEC, default 2, number of cascaded biquad sections (1..8).
REQ-005 SHALL have parameter ACC_W, default 40, accumulator width (at least DATA_W+COEF_W+3).
REQ-006 SHALL have port clk, input, 1, single system clock; all logic in this domain.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port l_r_clk, input, 1, asynchronous L/R select; each edge marks a new sample.
REQ-009 SHALL have port sample_in, input, DATA_W, x[n] for the channel given by the new l_r_clk level.
REQ-010 SHALL have port coef_wr_en, input, 1, shadow coefficient write strobe.
REQ-011 SHALL have port coef_wr_addr, input, $clog2(5*NUM_SEC), address = 5*section + k, with k: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
REQ-012 SHALL have port coef_wr_data, input, COEF_W, coefficient value.
REQ-013 SHALL have port coef_commit, input, 1, request to copy the shadow bank into the active bank.
REQ-014 SHALL have port overrun_clr, input, 1, clears the overrun flag.
REQ-015 SHALL have port sample_out, output, DATA_W, filtered y[n].
REQ-016 SHALL have port out_valid, output, 1, one-cycle pulse marking a new sample_out.
REQ-017 SHALL have port out_chan, output, 1, channel of sample_out (0 = left, 1 = right).
REQ-018 SHALL have port busy, output, 1, high while a computation is in progress.
REQ-019 SHALL have port overrun, output, 1, sticky flag for a sample edge dropped while busy.

Function
REQ-020 SHALL synchronise l_r_clk through two flops and generate a one-cycle edge pulse E on either edge; channel = synchronised level after the edge.
REQ-021 SHALL, on E in state IDLE or DONE, latch sample_in and the channel, then enter MAC.
REQ-022 SHALL use the state sequence IDLE -> per section {MAC k=0..4, one cycle each; SCALE, one cycle} -> DONE -> IDLE, costing 6 cycles per section.
REQ-023 SHALL use exactly one multiplier per cycle, shared across all sections and both channels.
REQ-024 SHALL clear the accumulator at MAC k=0 of every section, then accumulate b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2 at full ACC_W precision, subtracting the a terms rather than negating the coefficients.
REQ-025 SHALL, in SCALE, form acc + 2^(FRAC-1), arithmetic-shift right by FRAC, and saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-026 SHALL, in SCALE, update that section's channel history (x2<=x1, x1<=x, y2<=y1, y1<=y), and feed y as x to the next section.
REQ-027 SHALL keep separate history per section per channel; one channel's history SHALL never alter the other's.
REQ-028 SHALL, in the cycle E+6*NUM_SEC+1, assert out_valid for one cycle with sample_out = last-section y and out_chan set; sample_out and out_chan SHALL hold until the next out_valid.
REQ-029 SHALL assert busy from E+1 through the out_valid cycle inclusive.
REQ-030 SHALL, on E in any state other than IDLE or DONE, drop the sample, set overrun, and leave the computation in progress unaffected.
REQ-031 SHALL give overrun_clr priority over a simultaneous set, clearing overrun.
REQ-032 SHALL write coef_wr_en to the shadow bank at any time.
REQ-033 SHALL hold a coef_commit as pending and apply the shadow-to-active copy in the first cycle in IDLE (including the same cycle if already idle and no E occurs), so coefficients never change mid-sample.
REQ-034 SHALL, if E and a pending commit coincide in IDLE, apply the commit first; that sample SHALL use the new coefficients.
REQ-035 SHALL ignore writes to addresses >= 5*NUM_SEC.

Reset
REQ-036 SHALL, while reset=0, immediately force: state IDLE; sample_out=0; out_valid=0; out_chan=0; busy=0; overrun=0; all history=0; pending commit cleared.
REQ-037 SHALL reset both coefficient banks to passthrough (b0 = 2^FRAC, all other coefficients 0); reset mid-computation SHALL abort with no out_valid.

Verification
REQ-038 SHALL cover passthrough after reset: defaults, NUM_SEC=2, left edge with sample_in=0x1234 -> out_valid at E+13, sample_out=0x1234, out_chan=0.
REQ-039 SHALL cover gain and rounding: sec0 b0=0x2000, commit, inputs 0x4000 then 0x0001 -> outputs 0x2000 then 0x0001.
REQ-040 SHALL cover saturation: sec0 b0=0x7FFF, inputs 0x7FFF and 0x8000 -> outputs 0x7FFF and 0x8000.
REQ-041 SHALL cover feedback and channel isolation: sec0 a1=0xE000 (-0.5), left impulse 0x4000, 0, 0 -> left outputs 0x4000, 0x2000, 0x1000; interleaved right zeros -> right outputs 0.
REQ-042 SHALL cover overrun: a second edge at E+3 -> first output correct, overrun=1, no second out_valid; overrun_clr -> overrun=0.
REQ-043 SHALL cover async reset at E+4 -> busy=0 and out_valid=0 immediately, no output follows, and coefficients return to passthrough.
